ex_stage: RTL and testbench

- Execute stage. Sits directly downstream of the ID/EX pipeline register and upstream of the EX/MEM register.
- Consumes the registered operation (aluop, alusel, two operands, write address, write enable) and produces the write-back triple.
- Logic, shift and arithmetic ops complete in the same cycle.
- Divide/remainder ops run on an iterative 32-step divider and hold the pipeline with stall_req until the result is ready.

---
 rtl/ex_stage_pkg.sv | 52 +++++
 rtl/ex_stage_if.sv | 33 +++
 rtl/ex_stage_div_unit.sv | 140 ++++++++++++++
 rtl/ex_stage.sv | 136 +++++++++++++
 tb/tb_ex_stage.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// ex_stage_pkg : opcodes, class codes and divider state encoding for ex_stage
// Revision     : 1.0
// ============================================================================
package ex_stage_pkg;

   // operation codes
   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_AND  = 8'h01;
   localparam logic [7:0] OP_OR   = 8'h02;
   localparam logic [7:0] OP_XOR  = 8'h03;
   localparam logic [7:0] OP_NOR  = 8'h04;
   localparam logic [7:0] OP_SLL  = 8'h10;
   localparam logic [7:0] OP_SRL  = 8'h11;
   localparam logic [7:0] OP_SRA  = 8'h12;
   localparam logic [7:0] OP_ADD  = 8'h20;
   localparam logic [7:0] OP_SUB  = 8'h21;
   localparam logic [7:0] OP_SLT  = 8'h22;
   localparam logic [7:0] OP_SLTU = 8'h23;
   localparam logic [7:0] OP_DIV  = 8'h30;
   localparam logic [7:0] OP_DIVU = 8'h31;
   localparam logic [7:0] OP_REM  = 8'h32;
   localparam logic [7:0] OP_REMU = 8'h33;

   // operation classes
   localparam logic [2:0] SEL_NOP   = 3'd0;
   localparam logic [2:0] SEL_LOGIC = 3'd1;
   localparam logic [2:0] SEL_SHIFT = 3'd2;
   localparam logic [2:0] SEL_ARITH = 3'd3;
   localparam logic [2:0] SEL_DIV   = 3'd4;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   function automatic logic op_is_signed_div(input logic [7:0] op);
      return (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic op_is_quot(input logic [7:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic op_is_rem(input logic [7:0] op);
      return (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
// ex_stage_if : ID/EX operation bus in, EX/MEM write-back triple and stall out
// Revision    : 1.0
// ============================================================================
interface ex_stage_if #(
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int OPW  = 8,
   parameter int SELW = 3
);
   logic [OPW-1:0]  ex_aluop;
   logic [SELW-1:0] ex_alusel;
   logic [DW-1:0]   ex_reg0;
   logic [DW-1:0]   ex_reg1;
   logic [AW-1:0]   ex_waddr;
   logic            ex_we;
   logic [DW-1:0]   res_wdata;
   logic [AW-1:0]   res_waddr;
   logic            res_we;
   logic            stall_req;

   modport master (
      output ex_aluop, ex_alusel, ex_reg0, ex_reg1, ex_waddr, ex_we,
      input  res_wdata, res_waddr, res_we, stall_req
   );

   modport slave (
      input  ex_aluop, ex_alusel, ex_reg0, ex_reg1, ex_waddr, ex_we,
      output res_wdata, res_waddr, res_we, stall_req
   );
endinterface
`default_nettype wire

// File: rtl/ex_stage_div_unit.sv
`default_nettype none
// ============================================================================
// ex_stage_div_unit : 32-step restoring divider on magnitudes with sign fix-up
// Revision          : 1.0
// ============================================================================
module ex_stage_div_unit
   import ex_stage_pkg::*;
#(
   parameter int DW  = 32,
   parameter int AW  = 5,
   parameter int OPW = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start_i,
   input  logic           signed_i,
   input  logic [DW-1:0]  dividend_i,
   input  logic [DW-1:0]  divisor_i,
   input  logic [OPW-1:0] aluop_i,
   input  logic [AW-1:0]  waddr_i,
   input  logic           we_i,
   output logic           busy_o,
   output logic           done_o,
   output logic [DW-1:0]  quotient_o,
   output logic [DW-1:0]  remainder_o,
   output logic [OPW-1:0] aluop_o,
   output logic [AW-1:0]  waddr_o,
   output logic           we_o
);

   localparam int                 c_CNT_W = $clog2(DW);
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DW - 1);

   div_state_e           state_q, state_d;
   logic [c_CNT_W-1:0]   cnt_q;
   logic [DW-1:0]        quo_q, rem_q, dvs_q;
   logic                 qneg_q, rneg_q;
   logic [OPW-1:0]       op_q;
   logic [AW-1:0]        waddr_q;
   logic                 we_q;

   logic                 w_dvd_neg, w_dvs_neg, w_dvs_zero;
   logic [DW-1:0]        w_dvd_mag, w_dvs_mag;
   logic [DW:0]          w_shift, w_diff;
   logic                 w_take;

   assign w_dvd_neg  = signed_i & dividend_i[DW-1];
   assign w_dvs_neg  = signed_i & divisor_i[DW-1];
   assign w_dvd_mag  = w_dvd_neg ? (~dividend_i + 1'b1) : dividend_i;
   assign w_dvs_mag  = w_dvs_neg ? (~divisor_i + 1'b1) : divisor_i;
   assign w_dvs_zero = (divisor_i == '0);

   // Partial remainder carries one spare bit so the shifted value cannot overflow.
   assign w_shift = {rem_q, quo_q[DW-1]};
   assign w_diff  = w_shift - {1'b0, dvs_q};
   assign w_take  = ~w_diff[DW];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DIV_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         DIV_IDLE: begin
            if (start_i) begin
               state_d = w_dvs_zero ? DIV_DONE : DIV_RUN;
            end
         end
         DIV_RUN: begin
            if (cnt_q == c_LAST) begin
               state_d = DIV_DONE;
            end
         end
         DIV_DONE: state_d = DIV_IDLE;
         default:  state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         op_q    <= '0;
         waddr_q <= '0;
         we_q    <= 1'b0;
      end else begin
         case (state_q)
            DIV_IDLE: begin
               if (start_i) begin
                  cnt_q   <= '0;
                  op_q    <= aluop_i;
                  waddr_q <= waddr_i;
                  we_q    <= we_i;
                  dvs_q   <= w_dvs_mag;
                  // Divide by zero bypasses the sign fix so the raw dividend survives.
                  if (w_dvs_zero) begin
                     quo_q  <= '1;
                     rem_q  <= dividend_i;
                     qneg_q <= 1'b0;
                     rneg_q <= 1'b0;
                  end else begin
                     quo_q  <= w_dvd_mag;
                     rem_q  <= '0;
                     qneg_q <= w_dvd_neg ^ w_dvs_neg;
                     rneg_q <= w_dvd_neg;
                  end
               end
            end
            DIV_RUN: begin
               quo_q <= {quo_q[DW-2:0], w_take};
               rem_q <= w_take ? w_diff[DW-1:0] : w_shift[DW-1:0];
               cnt_q <= cnt_q + c_CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy_o      = ((state_q == DIV_IDLE) && start_i) || (state_q == DIV_RUN);
      done_o      = (state_q == DIV_DONE);
      quotient_o  = qneg_q ? (~quo_q + 1'b1) : quo_q;
      remainder_o = rneg_q ? (~rem_q + 1'b1) : rem_q;
   end

   assign aluop_o = op_q;
   assign waddr_o = waddr_q;
   assign we_o    = we_q;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// ex_stage : execute stage - single-cycle ALU plus iterative divider with stall
// Revision : 1.0
// ============================================================================
module ex_stage #(
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int OPW  = 8,
   parameter int SELW = 3
) (
   input  logic      clk,
   input  logic      rst,
   ex_stage_if.slave bus
);
   import ex_stage_pkg::*;

   localparam int c_SH_W = $clog2(DW);

   logic [OPW-1:0]    w_op;
   logic [SELW-1:0]   w_sel;
   logic [DW-1:0]     w_a, w_b;
   logic [c_SH_W-1:0] w_shamt;
   logic [DW-1:0]     w_alu_data;
   logic              w_alu_we;

   logic              w_div_start, w_div_signed, w_div_busy, w_div_done;
   logic [DW-1:0]     w_div_quot, w_div_rem;
   logic [OPW-1:0]    w_div_op;
   logic [AW-1:0]     w_div_waddr;
   logic              w_div_we;

   logic [DW-1:0]     w_res_wdata;
   logic [AW-1:0]     w_res_waddr;
   logic              w_res_we;
   logic              w_stall;

   assign w_op    = bus.ex_aluop;
   assign w_sel   = bus.ex_alusel;
   assign w_a     = bus.ex_reg0;
   assign w_b     = bus.ex_reg1;
   assign w_shamt = w_a[c_SH_W-1:0];

   always_comb begin
      w_alu_data = '0;
      w_alu_we   = bus.ex_we;
      case (w_sel)
         SEL_LOGIC: begin
            case (w_op)
               OP_AND:  w_alu_data = w_a & w_b;
               OP_OR:   w_alu_data = w_a | w_b;
               OP_XOR:  w_alu_data = w_a ^ w_b;
               OP_NOR:  w_alu_data = ~(w_a | w_b);
               default: w_alu_data = '0;
            endcase
         end
         SEL_SHIFT: begin
            case (w_op)
               OP_SLL:  w_alu_data = w_b << w_shamt;
               OP_SRL:  w_alu_data = w_b >> w_shamt;
               OP_SRA:  w_alu_data = $unsigned($signed(w_b) >>> w_shamt);
               default: w_alu_data = '0;
            endcase
         end
         SEL_ARITH: begin
            case (w_op)
               OP_ADD:  w_alu_data = w_a + w_b;
               OP_SUB:  w_alu_data = w_a - w_b;
               OP_SLT:  w_alu_data = {{(DW-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
               OP_SLTU: w_alu_data = {{(DW-1){1'b0}}, (w_a < w_b)};
               default: w_alu_data = '0;
            endcase
         end
         SEL_NOP: w_alu_we = 1'b0;
         default: w_alu_data = '0;
      endcase
   end

   assign w_div_start  = (w_sel == SEL_DIV);
   assign w_div_signed = op_is_signed_div(w_op);

   ex_stage_div_unit #(
      .DW  (DW),
      .AW  (AW),
      .OPW (OPW)
   ) u_div_unit (
      .clk         (clk),
      .rst         (rst),
      .start_i     (w_div_start),
      .signed_i    (w_div_signed),
      .dividend_i  (w_a),
      .divisor_i   (w_b),
      .aluop_i     (w_op),
      .waddr_i     (bus.ex_waddr),
      .we_i        (bus.ex_we),
      .busy_o      (w_div_busy),
      .done_o      (w_div_done),
      .quotient_o  (w_div_quot),
      .remainder_o (w_div_rem),
      .aluop_o     (w_div_op),
      .waddr_o     (w_div_waddr),
      .we_o        (w_div_we)
   );

   // A finished divide owns the result port for its DONE cycle; live inputs are ignored.
   always_comb begin
      w_res_wdata = '0;
      w_res_waddr = '0;
      w_res_we    = 1'b0;
      w_stall     = 1'b0;
      if (!rst) begin
         if (w_div_done) begin
            if (op_is_quot(w_div_op)) begin
               w_res_wdata = w_div_quot;
            end else if (op_is_rem(w_div_op)) begin
               w_res_wdata = w_div_rem;
            end
            w_res_waddr = w_div_waddr;
            w_res_we    = w_div_we;
         end else if (w_div_busy) begin
            w_stall = 1'b1;
         end else begin
            w_res_wdata = w_alu_data;
            w_res_waddr = bus.ex_waddr;
            w_res_we    = w_alu_we;
         end
      end
   end

   assign bus.res_wdata = w_res_wdata;
   assign bus.res_waddr = w_res_waddr;
   assign bus.res_we    = w_res_we;
   assign bus.stall_req = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// tb_ex_stage : vector table, hand sequences and randomized model checks
// Revision    : 1.0
// ============================================================================
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   ex_stage_if #(.DW(32), .AW(5), .OPW(8), .SELW(3)) bus ();

   ex_stage #(.DW(32), .AW(5), .OPW(8), .SELW(3)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  sel;
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  wa;
      logic        we;
      logic [31:0] exp_data;
      logic        exp_we;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] wa, input logic we);
      @(posedge clk);
      #1;
      bus.ex_alusel = sel;
      bus.ex_aluop  = op;
      bus.ex_reg0   = a;
      bus.ex_reg1   = b;
      bus.ex_waddr  = wa;
      bus.ex_we     = we;
   endtask

   // Reference: single-cycle result as {we, data}.
   function automatic logic [32:0] ref_alu(input logic [2:0] sel, input logic [7:0] op,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic we);
      logic [31:0] d;
      logic [4:0]  amt;
      longint      sb;
      d   = 32'h0;
      amt = a[4:0];
      sb  = $signed(b);
      case (sel)
         SEL_LOGIC: begin
            if (op == OP_AND) d = a & b;
            else if (op == OP_OR)  d = a | b;
            else if (op == OP_XOR) d = a ^ b;
            else if (op == OP_NOR) d = ~(a | b);
         end
         SEL_SHIFT: begin
            if (op == OP_SLL) d = b << amt;
            else if (op == OP_SRL) d = b >> amt;
            else if (op == OP_SRA) begin
               sb = sb >>> amt;
               d  = sb[31:0];
            end
         end
         SEL_ARITH: begin
            if (op == OP_ADD) d = a + b;
            else if (op == OP_SUB)  d = a - b;
            else if (op == OP_SLT)  d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            else if (op == OP_SLTU) d = (a < b) ? 32'd1 : 32'd0;
         end
         SEL_NOP: return {1'b0, 32'h0};
         default: d = 32'h0;
      endcase
      return {we, d};
   endfunction

   // Reference: divide computed in 64-bit arithmetic so INT_MIN/-1 needs no special case.
   function automatic logic [31:0] ref_div(input logic [7:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, q, r;
      logic   quot;
      quot = (op == OP_DIV) || (op == OP_DIVU);
      if (b == 32'h0) return quot ? 32'hFFFF_FFFF : a;
      if ((op == OP_DIV) || (op == OP_REM)) begin
         sa = $signed(a);
         sb = $signed(b);
      end else begin
         sa = longint'({32'h0, a});
         sb = longint'({32'h0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return quot ? q[31:0] : r[31:0];
   endfunction

   task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] wa, input logic we, input bit scramble,
                          output int stalls);
      logic [31:0] exp;
      int          exp_stalls;
      bit          done;
      exp        = ref_div(op, a, b);
      exp_stalls = (b == 32'h0) ? 1 : 33;
      stalls     = 0;
      done       = 1'b0;
      drive(SEL_DIV, op, a, b, wa, we);
      for (int cyc = 0; cyc < 100 && !done; cyc++) begin
         @(negedge clk);
         if (bus.stall_req) begin
            stalls++;
            check("div_we_during_stall", {31'h0, bus.res_we}, 32'h0);
            @(posedge clk);
            #1;
            if (scramble) begin
               bus.ex_alusel = 3'($urandom_range(0, 7));
               bus.ex_aluop  = 8'($urandom);
               bus.ex_reg0   = $urandom;
               bus.ex_reg1   = $urandom;
               bus.ex_waddr  = 5'($urandom);
               bus.ex_we     = 1'($urandom);
            end
         end else begin
            done = 1'b1;
            check("div_result", bus.res_wdata, exp);
            check("div_waddr", {27'h0, bus.res_waddr}, {27'h0, wa});
            check("div_we", {31'h0, bus.res_we}, {31'h0, we});
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL div_timeout actual=no_result expected=result_within_100_cycles");
      end
      check("div_stall_cycles", stalls, exp_stalls);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int          s1, s2;
      logic [2:0]  sel;
      logic [7:0]  op;
      logic [31:0] a, b;
      logic [4:0]  wa;
      logic        we;
      logic [32:0] exp;
      logic [7:0]  lops[4];
      logic [7:0]  sops[3];
      logic [7:0]  aops[4];
      logic [7:0]  dops[4];

      lops = '{OP_AND, OP_OR, OP_XOR, OP_NOR};
      sops = '{OP_SLL, OP_SRL, OP_SRA};
      aops = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU};
      dops = '{OP_DIV, OP_DIVU, OP_REM, OP_REMU};

      vecs[0]  = '{SEL_ARITH, OP_ADD,  32'd7,        32'hFFFF_FFFF, 5'd3,  1'b1, 32'd6,         1'b1};
      vecs[1]  = '{SEL_SHIFT, OP_SRA,  32'd4,        32'h8000_0000, 5'd7,  1'b1, 32'hF800_0000, 1'b1};
      vecs[2]  = '{SEL_ARITH, OP_SLTU, 32'd1,        32'hFFFF_FFFF, 5'd1,  1'b1, 32'd1,         1'b1};
      vecs[3]  = '{SEL_ARITH, OP_SLT,  32'd1,        32'hFFFF_FFFF, 5'd2,  1'b1, 32'd0,         1'b1};
      vecs[4]  = '{SEL_ARITH, OP_SUB,  32'd5,        32'd7,         5'd4,  1'b1, 32'hFFFF_FFFE, 1'b1};
      vecs[5]  = '{SEL_LOGIC, OP_AND,  32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd5,  1'b1, 32'h00F0_F000, 1'b1};
      vecs[6]  = '{SEL_LOGIC, OP_OR,   32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd6,  1'b0, 32'hFFF0_FFF0, 1'b0};
      vecs[7]  = '{SEL_LOGIC, OP_XOR,  32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd8,  1'b1, 32'hFF00_0FF0, 1'b1};
      vecs[8]  = '{SEL_LOGIC, OP_NOR,  32'hF0F0_FF00, 32'h0FF0_F0F0, 5'd9,  1'b1, 32'h000F_000F, 1'b1};
      vecs[9]  = '{SEL_SHIFT, OP_SLL,  32'h0000_0024, 32'h0000_00AB, 5'd10, 1'b1, 32'h0000_0AB0, 1'b1};
      vecs[10] = '{SEL_SHIFT, OP_SRL,  32'h0000_001F, 32'h8000_0000, 5'd11, 1'b1, 32'd1,         1'b1};
      vecs[11] = '{SEL_NOP,   OP_NOP,  32'h1234_5678, 32'h9ABC_DEF0, 5'd12, 1'b1, 32'd0,         1'b0};
      vecs[12] = '{SEL_LOGIC, 8'h05,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 1'b1, 32'd0,         1'b1};
      vecs[13] = '{3'd7,      OP_ADD,  32'd1,        32'd2,         5'd14, 1'b0, 32'd0,         1'b0};
      vecs[14] = '{SEL_ARITH, OP_SLT,  32'hFFFF_FFFB, 32'd3,         5'd15, 1'b1, 32'd1,         1'b1};
      vecs[15] = '{SEL_SHIFT, OP_SRA,  32'h0000_0020, 32'h8000_0001, 5'd16, 1'b1, 32'h8000_0001, 1'b1};

      // Reset with a live ADD on the bus: outputs must stay forced low.
      rst           = 1'b1;
      bus.ex_alusel = SEL_ARITH;
      bus.ex_aluop  = OP_ADD;
      bus.ex_reg0   = 32'd1;
      bus.ex_reg1   = 32'd2;
      bus.ex_waddr  = 5'd31;
      bus.ex_we     = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_wdata", bus.res_wdata, 32'h0);
      check("rst_waddr", {27'h0, bus.res_waddr}, 32'h0);
      check("rst_we", {31'h0, bus.res_we}, 32'h0);
      check("rst_stall", {31'h0, bus.stall_req}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (vecs[i]) begin
         drive(vecs[i].sel, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wa, vecs[i].we);
         @(negedge clk);
         check($sformatf("vec%0d_data", i), bus.res_wdata, vecs[i].exp_data);
         check($sformatf("vec%0d_we", i), {31'h0, bus.res_we}, {31'h0, vecs[i].exp_we});
         check($sformatf("vec%0d_waddr", i), {27'h0, bus.res_waddr}, {27'h0, vecs[i].wa});
         check($sformatf("vec%0d_stall", i), {31'h0, bus.stall_req}, 32'h0);
      end

      run_div(OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd20, 1'b1, 1'b0, s1);
      run_div(OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd21, 1'b1, 1'b0, s1);
      run_div(OP_DIVU, 32'd5, 32'd0, 5'd22, 1'b1, 1'b0, s1);
      run_div(OP_REMU, 32'd5, 32'd0, 5'd23, 1'b1, 1'b0, s1);
      run_div(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd24, 1'b1, 1'b0, s1);
      run_div(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd25, 1'b0, 1'b0, s1);

      // Back-to-back divides, then a bubble that must not repeat the last result.
      run_div(OP_DIVU, 32'd100, 32'd7, 5'd26, 1'b1, 1'b0, s1);
      run_div(OP_REMU, 32'd100, 32'd7, 5'd27, 1'b1, 1'b0, s2);
      check("b2b_total_stall", s1 + s2, 66);
      drive(SEL_NOP, OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      @(negedge clk);
      check("b2b_no_repeat_we", {31'h0, bus.res_we}, 32'h0);
      check("b2b_no_stall", {31'h0, bus.stall_req}, 32'h0);

      // Abort a divide at step 10.
      drive(SEL_DIV, OP_DIV, 32'd1000, 32'd3, 5'd9, 1'b1);
      repeat (11) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      check("abort_pre_stall", {31'h0, bus.stall_req}, 32'h1);
      rst           = 1'b1;
      bus.ex_alusel = SEL_NOP;
      bus.ex_aluop  = OP_NOP;
      @(negedge clk);
      check("abort_rst_stall", {31'h0, bus.stall_req}, 32'h0);
      check("abort_rst_we", {31'h0, bus.res_we}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check($sformatf("abort_idle%0d_stall", k), {31'h0, bus.stall_req}, 32'h0);
         check($sformatf("abort_idle%0d_we", k), {31'h0, bus.res_we}, 32'h0);
         @(posedge clk);
         #1;
      end
      drive(SEL_ARITH, OP_ADD, 32'd40, 32'd2, 5'd17, 1'b1);
      @(negedge clk);
      check("abort_add_data", bus.res_wdata, 32'd42);
      check("abort_add_we", {31'h0, bus.res_we}, 32'h1);
      run_div(OP_DIVU, 32'd1000, 32'd3, 5'd18, 1'b1, 1'b0, s1);

      // Randomized single-cycle ops against the model.
      for (int n = 0; n < 150; n++) begin
         sel = 3'($urandom_range(0, 4));
         if (sel == 3'd4) sel = 3'($urandom_range(5, 7));
         case (sel)
            SEL_LOGIC: op = lops[$urandom_range(0, 3)];
            SEL_SHIFT: op = sops[$urandom_range(0, 2)];
            SEL_ARITH: op = aops[$urandom_range(0, 3)];
            default:   op = 8'($urandom);
         endcase
         if ($urandom_range(0, 7) == 0) op = 8'($urandom);
         a   = $urandom;
         b   = $urandom;
         wa  = 5'($urandom);
         we  = 1'($urandom);
         exp = ref_alu(sel, op, a, b, we);
         drive(sel, op, a, b, wa, we);
         @(negedge clk);
         if ((bus.res_wdata !== exp[31:0]) || (bus.res_we !== exp[32]) ||
             (bus.res_waddr !== wa) || (bus.stall_req !== 1'b0)) begin
            $display("FAIL rand_alu sel=%0d op=0x%02h a=0x%08h b=0x%08h actual=0x%08h/we%0b/wa%0d/st%0b expected=0x%08h/we%0b/wa%0d/st0",
                     sel, op, a, b, bus.res_wdata, bus.res_we, bus.res_waddr, bus.stall_req,
                     exp[31:0], exp[32], wa);
            failures++;
         end
         checks++;
      end

      // Randomized divides, half of them with the upstream bus churning during the stall.
      for (int n = 0; n < 24; n++) begin
         op = dops[$urandom_range(0, 3)];
         case ($urandom_range(0, 5))
            0:       b = 32'h0;
            1:       b = $urandom_range(1, 15);
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
         run_div(op, a, b, 5'($urandom), 1'($urandom), bit'(n % 2), s1);
      end

      drive(SEL_NOP, OP_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
